// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies debounced key activity into short/long/double/repeat pulses
// Optional auto-repeat during a long hold is compiled in with `define KEY_REPEAT_EN.
module key_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned DCLICK_CYCLES = 15_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key_value,
  input  logic key_flag,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_HOLD,
    S_WAIT_REL
  } state_t;

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (64'(LONG_CYCLES) > CNT_MAX || 64'(DCLICK_CYCLES) > CNT_MAX ||
      64'(REPEAT_CYCLES) > CNT_MAX) begin : g_cnt_w_too_narrow
    $error("key_event_decoder: CNT_W cannot hold the largest cycle count");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             key_state_q, key_state_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             held_q, held_d;
  logic             repeat_d;
  logic             key_press, key_release;

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign key_press   = key_flag & ~key_value & key_state_q;
  assign key_release = key_flag & key_value & ~key_state_q;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_q;
`endif

  // Timeouts look at the incremented count so the registered pulse lands
  // exactly N cycles after the deciding flag; a key event always wins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    key_state_d = key_flag ? key_value : key_state_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    double_d    = 1'b0;
    repeat_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key_press) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (key_release) begin
          state_d = S_GAP;
        end else if (cnt_inc == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_GAP: begin
        if (key_press) begin
          double_d = 1'b1;
          state_d  = S_WAIT_REL;
        end else if (cnt_inc == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (key_release) begin
          state_d = S_IDLE;
`ifdef KEY_REPEAT_EN
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
`endif
        end
      end
      S_WAIT_REL: begin
        if (key_release) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    held_d = ~key_state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_state_q <= 1'b1;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      double_q    <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      short_q     <= short_d;
      long_q      <= long_d;
      double_q    <= double_d;
      held_q      <= held_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) repeat_q <= 1'b0;
    else     repeat_q <= repeat_d;
  end
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign double_pulse = double_q;
  assign held         = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - scoreboard bench for key_event_decoder
module tb_key_event_decoder;

  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DOUBLE = 3;
  localparam int K_REPEAT = 4;

  typedef struct packed {
    int kind;
    int cyc;
  } ev_t;

  logic clk, rst, key_value, key_flag;
  logic short_pulse, long_pulse, double_pulse, repeat_pulse, held;

  int  cyc;
  int  compared;
  int  mismatched;
  ev_t exp_q[$];

  key_event_decoder #(
    .LONG_CYCLES  (100),
    .DCLICK_CYCLES(40),
    .REPEAT_CYCLES(20),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_value   (key_value),
    .key_flag    (key_flag),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .double_pulse(double_pulse),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic step_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic flag(input logic v);
    key_flag  = 1'b1;
    key_value = v;
    @(negedge clk);
    key_flag  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_short"},  int'(short_pulse),  0);
    check({tag, "_long"},   int'(long_pulse),   0);
    check({tag, "_double"}, int'(double_pulse), 0);
    check({tag, "_repeat"}, int'(repeat_pulse), 0);
    check({tag, "_held"},   int'(held),         0);
  endtask

  // Every observed pulse is matched against the oldest expected event.
  always @(negedge clk) begin
    int  k;
    ev_t e;
    k = 0;
    if (!rst) begin
      if (short_pulse === 1'b1)       k = K_SHORT;
      else if (long_pulse === 1'b1)   k = K_LONG;
      else if (double_pulse === 1'b1) k = K_DOUBLE;
      else if (repeat_pulse === 1'b1) k = K_REPEAT;
      if (k != 0) begin
        check("onehot", $countones({short_pulse, long_pulse, double_pulse, repeat_pulse}), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_event", k, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", k, e.kind);
          check("event_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int t0;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    key_flag   = 1'b0;
    key_value  = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // short press
    t0 = cyc + 5;
    step_to(t0);
    check("short_held_before", int'(held), 0);
    flag(1'b0);
    check("short_held_t1", int'(held), 1);
    step_to(t0 + 30);
    check("short_held_t30", int'(held), 1);
    push(K_SHORT, t0 + 70);
    flag(1'b1);
    check("short_held_t31", int'(held), 0);
    step_to(t0 + 120);
    check("short_pending", exp_q.size(), 0);

    // double click, long hold in WAIT_REL gives nothing
    t0 = cyc + 5;
    step_to(t0);      flag(1'b0);
    step_to(t0 + 10); flag(1'b1);
    step_to(t0 + 30); push(K_DOUBLE, t0 + 31); flag(1'b0);
    step_to(t0 + 200); flag(1'b1);
    step_to(t0 + 300);
    check("double_pending", exp_q.size(), 0);

    // long press with optional repeat, release at +170
    t0 = cyc + 5;
    step_to(t0);
    push(K_LONG, t0 + 100);
`ifdef KEY_REPEAT_EN
    push(K_REPEAT, t0 + 120);
    push(K_REPEAT, t0 + 140);
    push(K_REPEAT, t0 + 160);
`endif
    flag(1'b0);
    step_to(t0 + 170); flag(1'b1);
    step_to(t0 + 260);
    check("long_pending", exp_q.size(), 0);

    // release on the decision cycle of the fourth repeat tick
    t0 = cyc + 5;
    step_to(t0);
    push(K_LONG, t0 + 100);
`ifdef KEY_REPEAT_EN
    push(K_REPEAT, t0 + 120);
    push(K_REPEAT, t0 + 140);
    push(K_REPEAT, t0 + 160);
`endif
    flag(1'b0);
    step_to(t0 + 179); flag(1'b1);
    step_to(t0 + 260);
    check("repeat_collide_pending", exp_q.size(), 0);

    // redundant flags are ignored and do not restart the count
    t0 = cyc + 5;
    step_to(t0);      flag(1'b1);
    step_to(t0 + 3);  flag(1'b1);
    check("redundant_held", int'(held), 0);
    step_to(t0 + 10); push(K_LONG, t0 + 110); flag(1'b0);
    step_to(t0 + 60); flag(1'b0);
    step_to(t0 + 115); flag(1'b1);
    step_to(t0 + 200);
    check("redundant_pending", exp_q.size(), 0);

    // release on the long-press decision cycle
    t0 = cyc + 5;
    step_to(t0);      flag(1'b0);
    step_to(t0 + 99); push(K_SHORT, t0 + 139); flag(1'b1);
    step_to(t0 + 200);
    check("long_collide_pending", exp_q.size(), 0);

    // second press on the short-press decision cycle
    t0 = cyc + 5;
    step_to(t0);      flag(1'b0);
    step_to(t0 + 10); flag(1'b1);
    step_to(t0 + 49); push(K_DOUBLE, t0 + 50); flag(1'b0);
    step_to(t0 + 60); flag(1'b1);
    step_to(t0 + 120);
    check("dclick_collide_pending", exp_q.size(), 0);

    // reset in the middle of a press
    t0 = cyc + 5;
    step_to(t0); flag(1'b0);
    step_to(t0 + 50);
    check("pre_reset_held", int'(held), 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    key_value = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step_to(cyc + 200);
    check("post_reset_held", int'(held), 0);
    check("post_reset_pending", exp_q.size(), 0);

    // decoder still works after reset
    t0 = cyc + 5;
    step_to(t0);      flag(1'b0);
    step_to(t0 + 20); push(K_SHORT, t0 + 60); flag(1'b1);
    step_to(t0 + 100);
    check("after_reset_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
